// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scanner with a one-deep pending buffer and leading-zero blanking
module seg_scan_ctrl #(
  parameter int DIGITS = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_lzb,
  output logic [3:0]  nibble,
  output logic [7:0]  an_n,
  output logic        frame
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CMAX = CW'(SCAN_DIV - 1);
  localparam logic [2:0] LAST = 3'(DIGITS - 1);
  localparam logic [31:0] MASK = 32'hFFFF_FFFF >> (32 - 4 * DIGITS);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [31:0] disp, pend;
  logic lzb, plzb, full, frame_q;
  logic acc, tick, wrap, blank, show;
  always_comb begin
    in_ready = !full && !rst;
    acc = in_valid && in_ready;
    tick = state == SCAN && cnt == CMAX;
    wrap = idx == LAST;
    state_n = state == IDLE && acc ? SCAN : state;
    // upper digits are masked on load, so a plain shift tests "this and all higher digits are zero"
    blank = lzb && idx != 3'd0 && (disp >> {idx, 2'b00}) == 32'd0;
    show = state == SCAN && !rst && !blank;
    an_n = show ? ~(8'd1 << idx) : 8'hFF;
    nibble = show ? disp[{idx, 2'b00} +: 4] : 4'd0;
    frame = frame_q && !rst;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      disp <= '0;
      pend <= '0;
      lzb <= 1'b0;
      plzb <= 1'b0;
      full <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state <= state_n;
      frame_q <= tick && wrap;
      if (state == IDLE) begin
        if (acc) begin
          disp <= in_data & MASK;
          lzb <= in_lzb;
        end
      end else begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (tick) idx <= wrap ? 3'd0 : idx + 3'd1;
        if (tick && wrap && full) begin
          disp <= pend;
          lzb <= plzb;
        end
        if (acc) begin
          pend <= in_data & MASK;
          plzb <= in_lzb;
        end
        full <= acc || (full && !(tick && wrap));
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed vectors with a queued scoreboard checked once per cycle at the falling edge
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst, in_valid, in_lzb, in_ready, frame;
  logic [31:0] in_data;
  logic [3:0] nibble;
  logic [7:0] an_n;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    string nm;
    logic [7:0] an;
    logic [3:0] nib;
    logic fr;
    logic rdy;
  } exp_t;
  exp_t q[$];
  exp_t e;
  seg_scan_ctrl #(.DIGITS(8), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_lzb(in_lzb), .nibble(nibble), .an_n(an_n), .frame(frame)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (an_n !== e.an || nibble !== e.nib || frame !== e.fr || in_ready !== e.rdy) begin
        miscompares++;
        $display("FAIL %s: an_n=%h nibble=%h frame=%b in_ready=%b, want an_n=%h nibble=%h frame=%b in_ready=%b",
                 e.nm, an_n, nibble, frame, in_ready, e.an, e.nib, e.fr, e.rdy);
      end
    end
  end
  task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic r);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data = d;
    in_lzb = l;
    rst = r;
  endtask
  task automatic raw(input string nm, input logic [7:0] an, input logic [3:0] nib, input logic fr, input logic rdy);
    exp_t x;
    x.nm = nm; x.an = an; x.nib = nib; x.fr = fr; x.rdy = rdy;
    q.push_back(x);
  endtask
  // c counts cycles since the first cycle of scanning; each digit is held for 4 cycles
  task automatic sc(input string nm, input logic v, input logic [31:0] d, input logic [31:0] val,
                    input logic l, input int c, input logic rdy);
    int k;
    logic blank;
    k = (c / 4) % 8;
    blank = l && k > 0 && (val >> (4 * k)) == 32'd0;
    drive(v, d, 1'b0, 1'b0);
    raw(nm, blank ? 8'hFF : ~(8'd1 << k), blank ? 4'd0 : val[4*k +: 4], c > 0 && c % 32 == 0, rdy);
  endtask
  task automatic do_reset();
    drive(1'b0, 32'd0, 1'b0, 1'b1);
    raw("reset", 8'hFF, 4'd0, 1'b0, 1'b0);
  endtask
  task automatic load(input logic [31:0] d, input logic l);
    drive(1'b1, d, l, 1'b0);
    raw("load", 8'hFF, 4'd0, 1'b0, 1'b1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_lzb = 1'b0;
    do_reset();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      raw("idle", 8'hFF, 4'd0, 1'b0, 1'b1);
    end
    load(32'h1234ABCD, 1'b0);
    for (int c = 0; c < 36; c++) sc("scan_1234abcd", 1'b0, 32'd0, 32'h1234ABCD, 1'b0, c, 1'b1);
    do_reset();
    load(32'h000000A5, 1'b1);
    for (int c = 0; c < 34; c++) sc("lzb_a5", 1'b0, 32'd0, 32'h000000A5, 1'b1, c, 1'b1);
    do_reset();
    load(32'h00000000, 1'b1);
    for (int c = 0; c < 34; c++) sc("lzb_zero", 1'b0, 32'd0, 32'h00000000, 1'b1, c, 1'b1);
    do_reset();
    load(32'h1234ABCD, 1'b0);
    for (int c = 0; c < 71; c++) begin
      if (c < 10) sc("pend_pre", 1'b0, 32'd0, 32'h1234ABCD, 1'b0, c, 1'b1);
      else if (c == 10) sc("pend_offer", 1'b1, 32'h11111111, 32'h1234ABCD, 1'b0, c, 1'b1);
      else if (c < 31) sc("pend_hold", 1'b1, 32'h33333333, 32'h1234ABCD, 1'b0, c, 1'b0);
      else if (c == 31) sc("pend_wrap", 1'b1, 32'h22222222, 32'h1234ABCD, 1'b0, c, 1'b0);
      else if (c == 32) sc("commit_ones", 1'b1, 32'h22222222, 32'h11111111, 1'b0, c, 1'b1);
      else if (c < 64) sc("ones_frame", 1'b0, 32'd0, 32'h11111111, 1'b0, c, 1'b0);
      else sc("commit_twos", 1'b0, 32'd0, 32'h22222222, 1'b0, c, 1'b1);
    end
    do_reset();
    load(32'h1234ABCD, 1'b0);
    for (int c = 0; c < 9; c++) begin
      if (c == 5) sc("rst_offer", 1'b1, 32'h00000055, 32'h1234ABCD, 1'b0, c, 1'b1);
      else sc("rst_scan", 1'b0, 32'd0, 32'h1234ABCD, 1'b0, c, c < 6);
    end
    drive(1'b0, 32'd0, 1'b0, 1'b1);
    raw("rst_mid", 8'hFF, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      raw("rst_idle", 8'hFF, 4'd0, 1'b0, 1'b1);
    end
    load(32'h00000007, 1'b1);
    for (int c = 0; c < 40; c++) sc("after_rst", 1'b0, 32'd0, 32'h00000007, 1'b1, c, 1'b1);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
